// File: rtl/slave_resp_arbiter.sv
// Round-robin arbiter that lends the master's serial read-data return line to one slave
// at a time, handshakes with master_ready and counts out a DATA_BITS-bit frame.
module slave_resp_arbiter #(
    parameter int N_SLAVES  = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_ready,
    input  logic [N_SLAVES-1:0] s_valid,
    input  logic [N_SLAVES-1:0] s_tx_data,
    output logic [N_SLAVES-1:0] s_master_ready,
    output logic [N_SLAVES-1:0] s_grant,
    output logic                m_tx_data,
    output logic                m_bit_valid,
    output logic                m_tx_done,
    output logic [2:0]          m_src,
    output logic                busy
);

    localparam int               CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS);
    localparam logic [2:0]       LAST_RST = 3'(N_SLAVES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] grant_q, grant_d;
    logic [2:0]          src_q, src_d;
    logic [2:0]          last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic       found_hi;
    logic       found_any;
    logic [2:0] pick_hi;
    logic [2:0] pick_any;
    logic [2:0] pick_idx;
    logic       granted_valid;

    // Lowest requester above the last served slave wins; otherwise wrap to the lowest requester.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        pick_hi   = '0;
        pick_any  = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (|(s_valid & (N_SLAVES'(1) << i))) begin
                found_any = 1'b1;
                pick_any  = 3'(i);
                if (i > int'(last_q)) begin
                    found_hi = 1'b1;
                    pick_hi  = 3'(i);
                end
            end
        end
    end

    assign pick_idx      = found_hi ? pick_hi : pick_any;
    assign granted_valid = |(s_valid & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found_any) begin
                    grant_d = N_SLAVES'(1) << pick_idx;
                    src_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!granted_valid) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (master_ready) begin
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // cnt 1..DATA_BITS mark the cycles carrying frame bits 0..DATA_BITS-1.
                if (cnt_q == CNT_LAST) begin
                    grant_d = '0;
                    last_d  = src_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            src_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_grant        = grant_q;
    assign s_master_ready = ((state_q == GRANT) && master_ready) ? grant_q : '0;
    assign m_tx_data      = |(s_tx_data & grant_q);
    assign m_bit_valid    = (state_q == BUSY) && (cnt_q != '0);
    assign m_tx_done      = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign m_src          = src_q;

endmodule

// File: tb/tb_slave_resp_arbiter.sv
// Self-checking bench for slave_resp_arbiter: directed reset/backpressure/withdraw/mid-frame
// reset steps plus randomized frames checked against a transaction-level round-robin model.
module tb_slave_resp_arbiter;

    localparam int N  = 3;
    localparam int DB = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         master_ready = 1'b0;
    logic [N-1:0] s_valid = '0;
    logic [N-1:0] s_tx_data = '0;
    logic [N-1:0] s_master_ready;
    logic [N-1:0] s_grant;
    logic         m_tx_data;
    logic         m_bit_valid;
    logic         m_tx_done;
    logic [2:0]   m_src;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int modelLast = N - 1;
    logic [N-1:0] plane [DB];

    slave_resp_arbiter #(.N_SLAVES(N), .DATA_BITS(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .master_ready   (master_ready),
        .s_valid        (s_valid),
        .s_tx_data      (s_tx_data),
        .s_master_ready (s_master_ready),
        .s_grant        (s_grant),
        .m_tx_data      (m_tx_data),
        .m_bit_valid    (m_bit_valid),
        .m_tx_done      (m_tx_done),
        .m_src          (m_src),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic mr);
        s_valid      = req;
        master_ready = mr;
    endtask

    // Round-robin rule: scan last+1, last+2, ... modulo N for the first requester.
    function automatic int expectWinner(input logic [N-1:0] req, input int last);
        int idx;
        for (int d = 1; d <= N; d++) begin
            idx = (last + d) % N;
            if ((req & (N'(1) << idx)) != '0) return idx;
        end
        return 0;
    endfunction

    task automatic randomPlanes();
        for (int i = 0; i < DB; i++) plane[i] = N'($urandom);
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, "_grant"}, 32'(s_grant), 32'(0));
        checkOutput({tag, "_smr"}, 32'(s_master_ready), 32'(0));
        checkOutput({tag, "_txd"}, 32'(m_tx_data), 32'(0));
        checkOutput({tag, "_bitv"}, 32'(m_bit_valid), 32'(0));
        checkOutput({tag, "_done"}, 32'(m_tx_done), 32'(0));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
        checkOutput({tag, "_src"}, 32'(m_src), 32'(0));
    endtask

    // One complete frame starting from IDLE; stall = cycles master_ready is held low in GRANT.
    task automatic runFrame(input logic [N-1:0] req, input int stall, input string tag);
        int w;
        logic [N-1:0] woh;
        w   = expectWinner(req, modelLast);
        woh = N'(1) << w;
        applyStimulus(req, stall == 0);
        s_tx_data = N'($urandom);
        @(posedge clk); #1;
        checkOutput({tag, "_grant"}, 32'(s_grant), 32'(woh));
        checkOutput({tag, "_src"}, 32'(m_src), 32'(w));
        checkOutput({tag, "_busyG"}, 32'(busy), 32'(1));
        checkOutput({tag, "_smrG"}, 32'(s_master_ready), (stall == 0) ? 32'(woh) : 32'(0));
        checkOutput({tag, "_txdG"}, 32'(m_tx_data), 32'(|(s_tx_data & woh)));
        for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_holdGrant"}, 32'(s_grant), 32'(woh));
            checkOutput({tag, "_holdSmr"}, 32'(s_master_ready), 32'(0));
        end
        master_ready = 1'b1;
        #1;
        checkOutput({tag, "_smrHs"}, 32'(s_master_ready), 32'(woh));
        @(posedge clk); #1;
        checkOutput({tag, "_bitv0"}, 32'(m_bit_valid), 32'(0));
        checkOutput({tag, "_smrB"}, 32'(s_master_ready), 32'(0));
        for (int i = 0; i < DB; i++) begin
            @(posedge clk); #1;
            s_tx_data = plane[i];
            #1;
            checkOutput({tag, "_bitv"}, 32'(m_bit_valid), 32'(1));
            checkOutput({tag, "_bit"}, 32'(m_tx_data), 32'(|(plane[i] & woh)));
            checkOutput({tag, "_doneEarly"}, 32'(m_tx_done), 32'(0));
        end
        @(posedge clk); #1;
        checkOutput({tag, "_done"}, 32'(m_tx_done), 32'(1));
        checkOutput({tag, "_grantClr"}, 32'(s_grant), 32'(0));
        checkOutput({tag, "_bitvD"}, 32'(m_bit_valid), 32'(0));
        checkOutput({tag, "_srcD"}, 32'(m_src), 32'(w));
        modelLast = w;
        @(posedge clk); #1;
        checkOutput({tag, "_doneOnce"}, 32'(m_tx_done), 32'(0));
        checkOutput({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        logic [7:0] byteA5;
        logic [N-1:0] req;

        $display("[TB] reset state");
        applyStimulus('1, 1'b1);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkIdleReset("rst");
        end

        $display("[TB] release, backpressure and withdraw");
        master_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("relGrant", 32'(s_grant), 32'(1));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bpGrant", 32'(s_grant), 32'(1));
            checkOutput("bpSmr", 32'(s_master_ready), 32'(0));
        end
        applyStimulus('0, 1'b0);
        @(posedge clk); #1;
        checkOutput("wdGrant", 32'(s_grant), 32'(0));
        checkOutput("wdBusy", 32'(busy), 32'(0));
        randomPlanes();
        runFrame('1, 0, "regrant");

        $display("[TB] single frame 0xA5 from slave 1");
        byteA5 = 8'hA5;
        for (int i = 0; i < DB; i++)
            plane[i] = (N'($urandom) & ~N'(2)) | ((((byteA5 >> i) & 8'h01) != 0) ? N'(2) : N'(0));
        runFrame(N'(2), 0, "a5");

        $display("[TB] round-robin with all slaves requesting");
        for (int f = 0; f < 4; f++) begin
            randomPlanes();
            runFrame('1, 0, "rr");
        end

        $display("[TB] randomized frames");
        for (int f = 0; f < 12; f++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            randomPlanes();
            runFrame(req, int'($urandom_range(0, 3)), "rand");
        end

        $display("[TB] reset mid-frame");
        randomPlanes();
        runFrame(N'(1), 0, "pre");
        applyStimulus(N'(2), 1'b1);
        @(posedge clk); #1;
        checkOutput("midGrant", 32'(s_grant), 32'(2));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            s_tx_data = plane[i];
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checkIdleReset("midRst");
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checkOutput("midRstDone", 32'(m_tx_done), 32'(0));
            checkOutput("midRstBusy", 32'(busy), 32'(0));
        end
        reset = 1'b1;
        modelLast = N - 1;
        randomPlanes();
        runFrame('1, 0, "postRst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
